// File: rtl/gb_line_burst_writer.sv
// Game Boy pixel stream to frame-buffer burst writer: FWFT pixel FIFO, two-entry
// line segment tracker and a request/ack/pull burst FSM in the hClk domain.
//
// state | meaning
// IDLE  | no burst in flight; evaluates the head segment for the next burst
// REQ   | memReq high, memAddr/memLen held until memAck
// DATA  | controller pulls memLen words from the FIFO head
module gb_line_burst_writer #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 23
) (
  input  logic                        hClk,
  input  logic                        reset,
  input  logic                        hGBNewLine,
  input  logic [ADDR_W-1:0]           hGBAddress,
  input  logic                        hGBWrite,
  input  logic [15:0]                 hGBData,
  output logic                        memReq,
  output logic [ADDR_W-1:0]           memAddr,
  output logic [5:0]                  memLen,
  input  logic                        memAck,
  input  logic                        memDataRd,
  output logic [15:0]                 memData,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  output logic                        overflow,
  output logic                        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] BURST_CNT = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] DEPTH_CNT = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DATA} stateT;
  typedef enum logic [1:0] {SEG_NONE, SEG_CUR, SEG_NXT, SEG_DROP} openT;

  stateT             state;
  openT              openSeg;
  logic              inNewLine, inWrite;
  logic [ADDR_W-1:0] inAddr;
  logic [15:0]       inData;
  logic              curValid, curClosed, nxtValid, nxtClosed;
  logic [ADDR_W-1:0] curBase, nxtBase;
  logic [LVL_W-1:0]  curCount, nxtCount;
  logic [15:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [5:0]        popCnt;

  logic             fifoFull, curFree, openNew, openToCur, openToNxt, openDrop;
  logic             toCur, toNxt, push, pop, closeCur, closeNxt, promote, issue;
  logic [5:0]       issueLen;
  logic [LVL_W-1:0] incCur, incNxt, decCur;

  always_comb begin
    fifoFull  = fifoLevel == DEPTH_CNT;
    curFree   = !curValid || (curClosed && curCount == '0);
    openNew   = inWrite && openSeg == SEG_NONE;
    openToCur = openNew && curFree && !nxtValid;
    openToNxt = openNew && !curFree && !nxtValid;
    openDrop  = openNew && nxtValid;
    toCur     = inWrite && (openSeg == SEG_CUR || openToCur);
    toNxt     = inWrite && (openSeg == SEG_NXT || openToNxt);
    push      = (toCur || toNxt) && !fifoFull;
    pop       = state == DATA && memDataRd && fifoLevel != '0;
    closeCur  = inNewLine && (openSeg == SEG_CUR || openToCur);
    closeNxt  = inNewLine && (openSeg == SEG_NXT || openToNxt);
    promote   = state == IDLE && curValid && curClosed && curCount == '0 && nxtValid;
    issue     = state == IDLE && curValid &&
                (curCount >= BURST_CNT || (curClosed && curCount != '0));
    issueLen  = (curCount >= BURST_CNT) ? 6'(BURST_LEN) : 6'(curCount);
    incCur    = LVL_W'(push && toCur);
    incNxt    = LVL_W'(push && toNxt);
    decCur    = issue ? LVL_W'(issueLen) : '0;
  end

  assign memData = (state == DATA) ? fifoMem[rdPtr] : '0;
  assign busy    = state != IDLE || fifoLevel != '0;

  always_ff @(posedge hClk) begin
    if (push) fifoMem[wrPtr] <= inData;
  end

  // Inputs are registered once so segment decisions see a whole, aligned pixel event.
  always_ff @(posedge hClk) begin
    if (reset) begin
      inNewLine <= 1'b0;
      inWrite   <= 1'b0;
      inAddr    <= '0;
      inData    <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
      overflow  <= 1'b0;
      openSeg   <= SEG_NONE;
      curValid  <= 1'b0;
      curClosed <= 1'b0;
      curBase   <= '0;
      curCount  <= '0;
      nxtValid  <= 1'b0;
      nxtClosed <= 1'b0;
      nxtBase   <= '0;
      nxtCount  <= '0;
    end else begin
      inNewLine <= hGBNewLine;
      inWrite   <= hGBWrite;
      inAddr    <= hGBAddress;
      inData    <= hGBData;

      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      fifoLevel <= fifoLevel + LVL_W'(push) - LVL_W'(pop);
      if (openDrop || ((toCur || toNxt) && fifoFull)) overflow <= 1'b1;

      if (inNewLine)                          openSeg <= SEG_NONE;
      else if (openToCur)                     openSeg <= SEG_CUR;
      else if (openToNxt)                     openSeg <= SEG_NXT;
      else if (openDrop)                      openSeg <= SEG_DROP;
      else if (promote && openSeg == SEG_NXT) openSeg <= SEG_CUR;

      if (openToCur) begin
        curValid  <= 1'b1;
        curClosed <= inNewLine;
        curBase   <= inAddr;
        curCount  <= incCur;
      end else if (promote) begin
        curValid  <= 1'b1;
        curClosed <= nxtClosed || closeNxt;
        curBase   <= nxtBase;
        curCount  <= nxtCount + incNxt;
      end else begin
        curClosed <= curClosed || closeCur;
        curCount  <= curCount + incCur - decCur;
        if (issue) curBase <= curBase + ADDR_W'(issueLen);
      end

      if (promote) begin
        nxtValid  <= 1'b0;
        nxtClosed <= 1'b0;
        nxtBase   <= '0;
        nxtCount  <= '0;
      end else if (openToNxt) begin
        nxtValid  <= 1'b1;
        nxtClosed <= inNewLine;
        nxtBase   <= inAddr;
        nxtCount  <= incNxt;
      end else begin
        nxtClosed <= nxtClosed || closeNxt;
        nxtCount  <= nxtCount + incNxt;
      end
    end
  end

  always_ff @(posedge hClk) begin
    if (reset) begin
      state   <= IDLE;
      memReq  <= 1'b0;
      memAddr <= '0;
      memLen  <= '0;
      popCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            memAddr <= curBase;
            memLen  <= issueLen;
            memReq  <= 1'b1;
            popCnt  <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (memAck) begin
            memReq <= 1'b0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (pop) begin
            popCnt <= popCnt + 6'd1;
            if (popCnt + 6'd1 == memLen) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_line_burst_writer.sv
// Self-checking bench for gb_line_burst_writer: line table, randomized line pairs
// against a burst/data queue model, and hand sequences for overflow, drop and reset.
module tb_gb_line_burst_writer;
  localparam int BL = 16;
  localparam int AW = 23;

  logic          hClk = 1'b0;
  logic          reset, hGBNewLine, hGBWrite;
  logic [AW-1:0] hGBAddress;
  logic [15:0]   hGBData;
  logic          memReq, memAck, memDataRd, overflow, busy;
  logic [AW-1:0] memAddr;
  logic [5:0]    memLen;
  logic [15:0]   memData;
  logic [6:0]    fifoLevel;

  logic autoCtl, ackHold, autoAck, autoRd, manAck, manRd;
  assign memAck    = autoCtl ? autoAck : manAck;
  assign memDataRd = autoCtl ? autoRd  : manRd;

  always #5 hClk = ~hClk;

  gb_line_burst_writer #(.BURST_LEN(BL), .FIFO_DEPTH(64), .ADDR_W(AW)) dut (
    .hClk(hClk), .reset(reset), .hGBNewLine(hGBNewLine), .hGBAddress(hGBAddress),
    .hGBWrite(hGBWrite), .hGBData(hGBData), .memReq(memReq), .memAddr(memAddr),
    .memLen(memLen), .memAck(memAck), .memDataRd(memDataRd), .memData(memData),
    .fifoLevel(fifoLevel), .overflow(overflow), .busy(busy)
  );

  typedef struct {logic [AW-1:0] addr; int len;} burstT;
  typedef struct {logic [AW-1:0] base; int nPix; int nlMode; int expBursts; int expLastLen;} vecT;

  burstT       expBurstQ[$];
  logic [15:0] expDataQ[$];
  int passCnt = 0, totalCnt = 0, burstCnt = 0, lastLen = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endfunction

  // Reference: a line becomes consecutive bursts of up to BL words from its base.
  function automatic void addExpect(input logic [AW-1:0] base, input logic [15:0] d[$]);
    for (int off = 0; off < d.size(); off += BL) begin
      burstT b;
      b.addr = base + AW'(off);
      b.len  = (d.size() - off > BL) ? BL : d.size() - off;
      expBurstQ.push_back(b);
    end
    foreach (d[i]) expDataQ.push_back(d[i]);
  endfunction

  initial begin : ctrl
    burstT       b;
    logic [15:0] e;
    int          len;
    autoAck = 1'b0;
    autoRd  = 1'b0;
    forever begin
      @(negedge hClk);
      if (autoCtl && memReq && !reset) begin
        len = int'(memLen);
        burstCnt++;
        lastLen = len;
        if (expBurstQ.size() == 0) begin
          totalCnt++;
          $display("FAIL burst unexpected: got addr 0x%0h len %0d, expected none", memAddr, len);
        end else begin
          b = expBurstQ.pop_front();
          check("burst addr", 32'(memAddr), 32'(b.addr));
          check("burst len", 32'(len), 32'(b.len));
        end
        while (ackHold) @(negedge hClk);
        repeat ($urandom_range(0, 3)) @(negedge hClk);
        autoAck = 1'b1;
        @(negedge hClk);
        autoAck = 1'b0;
        for (int k = 0; k < len; k++) begin
          repeat ($urandom_range(0, 1)) @(negedge hClk);
          if (expDataQ.size() == 0) begin
            totalCnt++;
            $display("FAIL pop data: got 0x%0h, expected no word", memData);
          end else begin
            e = expDataQ.pop_front();
            check("pop data", 32'(memData), 32'(e));
          end
          autoRd = 1'b1;
          @(negedge hClk);
          autoRd = 1'b0;
        end
      end
    end
  end

  task automatic pixel(input logic [AW-1:0] a, input logic [15:0] d, input logic nl);
    hGBWrite   = 1'b1;
    hGBAddress = a;
    hGBData    = d;
    hGBNewLine = nl;
    @(negedge hClk);
    hGBWrite   = 1'b0;
    hGBNewLine = 1'b0;
  endtask

  task automatic newLinePulse();
    hGBNewLine = 1'b1;
    @(negedge hClk);
    hGBNewLine = 1'b0;
  endtask

  // nlMode 1: newline with last pixel, 2: newline one cycle after; keep = pixels expected to land
  task automatic sendLine(input logic [AW-1:0] base, input int n, input int nlMode,
                          input int gapMin, input int gapMax, input int keep);
    logic [15:0] dq[$];
    logic [15:0] kq[$];
    for (int i = 0; i < n; i++) begin
      dq.push_back(16'($urandom));
      if (i < keep) kq.push_back(dq[i]);
    end
    addExpect(base, kq);
    for (int i = 0; i < n; i++) begin
      pixel(base, dq[i], nlMode == 1 && i == n - 1);
      repeat ($urandom_range(gapMin, gapMax)) @(negedge hClk);
    end
    if (nlMode == 2) newLinePulse();
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    int cnt;
    cnt = 0;
    repeat (3) @(negedge hClk);
    while (busy && cnt < maxCycles) begin
      @(negedge hClk);
      cnt++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge hClk);
    reset = 1'b0;
  endtask

  task automatic manualPops(input logic [15:0] dq[$], input int n);
    manAck = 1'b1;
    @(negedge hClk);
    manAck = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("manual pop data", 32'(memData), 32'(dq[k]));
      manRd = 1'b1;
      @(negedge hClk);
      manRd = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vecT         vecs[6];
    logic [15:0] dq[$];
    int          bc;
    reset = 1'b1; hGBNewLine = 1'b0; hGBWrite = 1'b0; hGBAddress = '0; hGBData = '0;
    autoCtl = 1'b1; ackHold = 1'b0; manAck = 1'b0; manRd = 1'b0;

    vecs[0] = '{23'h10000, 160, 2, 10, 16};
    vecs[1] = '{23'h10140, 20, 2, 2, 4};
    vecs[2] = '{23'h20000, 5, 1, 1, 5};
    vecs[3] = '{23'h20100, 33, 1, 3, 1};
    vecs[4] = '{23'h7FFFF8, 20, 2, 2, 4};
    vecs[5] = '{23'h00123, 16, 2, 1, 16};

    repeat (3) @(negedge hClk);
    check("reset memReq", 32'(memReq), 32'd0);
    check("reset memAddr", 32'(memAddr), 32'd0);
    check("reset memLen", 32'(memLen), 32'd0);
    check("reset memData", 32'(memData), 32'd0);
    check("reset fifoLevel", 32'(fifoLevel), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge hClk);

    foreach (vecs[i]) begin
      bc = burstCnt;
      sendLine(vecs[i].base, vecs[i].nPix, vecs[i].nlMode, 1, 2, vecs[i].nPix);
      waitIdle(3000, "table busy idle");
      check("table burst count", 32'(burstCnt - bc), 32'(vecs[i].expBursts));
      check("table last len", 32'(lastLen), 32'(vecs[i].expLastLen));
    end

    for (int p = 0; p < 8; p++) begin
      for (int l = 0; l < 2; l++) begin
        sendLine(AW'($urandom), $urandom_range(1, 32), $urandom_range(1, 2), 0, 2, 64);
        repeat ($urandom_range(0, 3)) @(negedge hClk);
      end
      waitIdle(1000, "random busy idle");
    end
    check("random overflow", 32'(overflow), 32'd0);

    // FIFO fills to depth while the first request is held; the next pixel must be dropped
    ackHold = 1'b1;
    bc = burstCnt;
    dq.delete();
    for (int i = 0; i < 64; i++) dq.push_back(16'($urandom));
    addExpect(23'h70000, dq);
    for (int i = 0; i < 64; i++) pixel(23'h70000, dq[i], 1'b0);
    repeat (2) @(negedge hClk);
    check("full fifoLevel", 32'(fifoLevel), 32'd64);
    check("full overflow", 32'(overflow), 32'd0);
    pixel(23'h70000, 16'hDEAD, 1'b0);
    repeat (2) @(negedge hClk);
    check("drop fifoLevel", 32'(fifoLevel), 32'd64);
    check("drop overflow", 32'(overflow), 32'd1);
    newLinePulse();
    ackHold = 1'b0;
    waitIdle(1000, "full busy idle");
    check("full burst count", 32'(burstCnt - bc), 32'd4);

    doReset();
    @(negedge hClk);
    check("overflow cleared", 32'(overflow), 32'd0);

    // Two closed lines pending, third line has no segment slot
    ackHold = 1'b1;
    bc = burstCnt;
    sendLine(23'h30000, 20, 2, 0, 0, 20);
    sendLine(23'h30100, 10, 2, 0, 0, 10);
    repeat (3) @(negedge hClk);
    check("two lines overflow", 32'(overflow), 32'd0);
    sendLine(23'h30200, 5, 2, 0, 0, 0);
    repeat (3) @(negedge hClk);
    check("third line overflow", 32'(overflow), 32'd1);
    ackHold = 1'b0;
    waitIdle(1000, "segment busy idle");
    check("segment burst count", 32'(burstCnt - bc), 32'd3);

    // Partial burst latency after a closing newline
    doReset();
    autoCtl = 1'b0;
    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back(16'($urandom));
    for (int i = 0; i < 3; i++) pixel(23'h60000, dq[i], 1'b0);
    newLinePulse();
    @(negedge hClk);
    check("newline req early", 32'(memReq), 32'd0);
    @(negedge hClk);
    check("newline req rise", 32'(memReq), 32'd1);
    check("newline addr", 32'(memAddr), 32'h60000);
    check("newline len", 32'(memLen), 32'd3);
    manualPops(dq, 3);
    waitIdle(50, "newline busy idle");

    // Full burst latency, then reset in DATA after 3 pops
    dq.delete();
    for (int i = 0; i < 16; i++) dq.push_back(16'($urandom));
    for (int i = 0; i < 16; i++) pixel(23'h40000, dq[i], 1'b0);
    @(negedge hClk);
    check("full req early", 32'(memReq), 32'd0);
    @(negedge hClk);
    check("full req rise", 32'(memReq), 32'd1);
    check("full addr", 32'(memAddr), 32'h40000);
    check("full len", 32'(memLen), 32'd16);
    manualPops(dq, 3);
    reset = 1'b1;
    @(negedge hClk);
    check("reset data memReq", 32'(memReq), 32'd0);
    check("reset data fifoLevel", 32'(fifoLevel), 32'd0);
    check("reset data busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge hClk);
    autoCtl = 1'b1;
    bc = burstCnt;
    sendLine(23'h50000, 16, 2, 0, 0, 16);
    waitIdle(200, "after reset busy idle");
    check("after reset bursts", 32'(burstCnt - bc), 32'd1);
    check("after reset len", 32'(lastLen), 32'd16);

    check("bursts left", 32'(expBurstQ.size()), 32'd0);
    check("words left", 32'(expDataQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
